// File: rtl/rv_core_pkg.sv
// Shared core definitions: datapath and register-file geometry, writeback FSM
// states and small register-index helpers.
package rv_core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } wb_state_t;

    // x0 is hard-wired, so it never carries a real destination.
    function automatic logic reg_is_live(input logic [REG_ADDR_W-1:0] idx);
        return idx != {REG_ADDR_W{1'b0}};
    endfunction

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic en,
                                                       input logic [REG_ADDR_W-1:0] idx);
        return {{(NUM_REGS-1){1'b0}}, en} << idx;
    endfunction

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// Bundle between decode/execute/memory and the register-file write controller.
interface rf_writeback_ctrl_if;
    import rv_core_pkg::*;

    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_rs1;
    logic [REG_ADDR_W-1:0] iss_rs2;
    logic [REG_ADDR_W-1:0] iss_rd;
    logic                  stall;
    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_a3;
    logic [XLEN-1:0]       rf_wd;
    logic                  err_unexp;

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd,
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  stall, ld_ready, rf_we, rf_a3, rf_wd, err_unexp
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd,
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output stall, ld_ready, rf_we, rf_a3, rf_wd, err_unexp
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending bits with set-on-issue / clear-on-commit and hazard lookups.
module rf_scoreboard import rv_core_pkg::*; (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] res_idx,
    output logic                  hz_rs1,
    output logic                  hz_rs2,
    output logic                  hz_rd,
    output logic                  res_pending
);

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pend_next_s;

    // Set is applied after clear so a same-index collision keeps the bit set.
    always_comb begin
        pend_next_s = (pending_r & ~reg_onehot(clr_en, clr_idx)) | reg_onehot(set_en, set_idx);
    end

    // Pending state; bit 0 is forced low so x0 can never raise a hazard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= {NUM_REGS{1'b0}};
        end else begin
            pending_r <= {pend_next_s[NUM_REGS-1:1], 1'b0};
        end
    end

    assign hz_rs1      = pending_r[rs1];
    assign hz_rs2      = pending_r[rs2];
    assign hz_rd       = pending_r[rd];
    assign res_pending = pending_r[res_idx];

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port owner: ALU-over-load arbitration, registered write
// port, unexpected-result flag and load starvation guard.
module rf_writeback_ctrl import rv_core_pkg::*; #(
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    rf_writeback_ctrl_if.slave  wb
);

    localparam int                 CNT_W    = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STARVE_MAX - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(STARVE_MAX);

    wb_state_t             state_r, state_next_s;
    logic [CNT_W-1:0]      cnt_r, cnt_next_s;
    logic                  rf_we_r;
    logic [REG_ADDR_W-1:0] rf_a3_r;
    logic [XLEN-1:0]       rf_wd_r;
    logic                  err_r;

    logic                  hz_rs1_s, hz_rs2_s, hz_rd_s, res_pend_s;
    logic                  stall_s, iss_acc_s, ld_ready_s, ld_blocked_s;
    logic                  res_valid_s;
    logic [REG_ADDR_W-1:0] res_rd_s;
    logic [XLEN-1:0]       res_data_s;

    // Loads are refused during reset so an in-flight result is dropped, not written.
    assign ld_ready_s   = ~wb.alu_valid & ~reset;
    assign ld_blocked_s = wb.ld_valid & ~ld_ready_s;
    assign stall_s      = (state_r == FORCE) | (wb.iss_valid & (hz_rs1_s | hz_rs2_s | hz_rd_s));
    assign iss_acc_s    = wb.iss_valid & ~stall_s;

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en      (iss_acc_s),
        .set_idx     (wb.iss_rd),
        .clr_en      (rf_we_r),
        .clr_idx     (rf_a3_r),
        .rs1         (wb.iss_rs1),
        .rs2         (wb.iss_rs2),
        .rd          (wb.iss_rd),
        .res_idx     (res_rd_s),
        .hz_rs1      (hz_rs1_s),
        .hz_rs2      (hz_rs2_s),
        .hz_rd       (hz_rd_s),
        .res_pending (res_pend_s)
    );

    // Select the one result that owns the write port this cycle.
    always_comb begin
        res_valid_s = 1'b0;
        res_rd_s    = {REG_ADDR_W{1'b0}};
        res_data_s  = {XLEN{1'b0}};
        if (wb.alu_valid) begin
            res_valid_s = 1'b1;
            res_rd_s    = wb.alu_rd;
            res_data_s  = wb.alu_data;
        end else if (wb.ld_valid && ld_ready_s) begin
            res_valid_s = 1'b1;
            res_rd_s    = wb.ld_rd;
            res_data_s  = wb.ld_data;
        end else begin
            res_valid_s = 1'b0;
        end
    end

    // Registered write port; an x0 result completes its handshake but writes nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_r <= 1'b0;
            rf_a3_r <= {REG_ADDR_W{1'b0}};
            rf_wd_r <= {XLEN{1'b0}};
        end else if (res_valid_s) begin
            rf_we_r <= reg_is_live(res_rd_s);
            rf_a3_r <= res_rd_s;
            rf_wd_r <= res_data_s;
        end else begin
            rf_we_r <= 1'b0;
        end
    end

    // Sticky flag for a result that no issued instruction is waiting on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (res_valid_s && reg_is_live(res_rd_s) && !res_pend_s) begin
            err_r <= 1'b1;
        end
    end

    // Starvation FSM state and blocked-cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Count consecutive blocked load cycles; FORCE stops issue so the ALU drains.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (ld_blocked_s) begin
                    state_next_s = WAIT;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    cnt_next_s   = CNT_ZERO;
                end
            end
            WAIT: begin
                if (!ld_blocked_s) begin
                    state_next_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r >= CNT_LAST) begin
                    state_next_s = FORCE;
                    cnt_next_s   = CNT_MAX;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            FORCE: begin
                if (!ld_blocked_s) begin
                    state_next_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = CNT_MAX;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    assign wb.stall     = stall_s;
    assign wb.ld_ready  = ld_ready_s;
    assign wb.rf_we     = rf_we_r;
    assign wb.rf_a3     = rf_a3_r;
    assign wb.rf_wd     = rf_wd_r;
    assign wb.err_unexp = err_r;

endmodule
